// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM encoding, NOP filler, bus OKAY code and the lane-select helper.
package ysyx_22050550_ifu_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_AR   = 3'd1,
    IFU_R    = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_DROP = 3'd4
  } ifu_state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  function automatic logic [31:0] pick_inst(
    input logic [63:0] line,
    input logic        hi
  );
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050550_ifu_linebuf.sv
// One-entry 64-bit fetch line buffer: tag/data/valid plus hit compare.
// Ports: clock/reset, fill (tag,data), inval, lookup tag -> hit, line.
module ysyx_22050550_ifu_linebuf
  import ysyx_22050550_ifu_pkg::*;
#(
  parameter int TAG_W  = 61,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval,
  input  logic [TAG_W-1:0]  look_tag,
  output logic              hit,
  output logic [DATA_W-1:0] line
);

  logic              valid;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign hit  = valid && (tag == look_tag);
  assign line = data;

endmodule

// File: rtl/ysyx_22050550_ifu.sv
// IFU: samples npc, one 64-bit AR/R read, presents {pc,inst,fault} to ID.
// Ports: pc_i/pc_ready_o/redirect_i, AR/R bus, if_* to ID.
// Option: YSYX_22050550_IFU_LINEBUF_EN adds a one-entry line buffer.
module ysyx_22050550_ifu
  import ysyx_22050550_ifu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_ready_o,
  input  logic              redirect_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic              if_valid_o,
  input  logic              if_ready_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_fault_o
);

  ifu_state_t        state;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic              fault_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              valid_q;
  logic              kill_q;

  logic              r_fire;
  logic              misalign;
  logic              hit;
  logic [DATA_W-1:0] line;

  assign r_fire   = rvalid_i && rready_q;
  assign misalign = pc_i[1:0] != 2'b00;

`ifdef YSYX_22050550_IFU_LINEBUF_EN
  logic fill;
  logic inval;

  // DROP responses still fill: pc_q keeps the address of the read.
  assign fill  = r_fire && (rresp_i == RESP_OKAY);
  assign inval = (state == IFU_IDLE && misalign)
              || (r_fire && rresp_i != RESP_OKAY);

  ysyx_22050550_ifu_linebuf #(
    .TAG_W  (ADDR_W - 3),
    .DATA_W (DATA_W)
  ) u_linebuf (
    .clock     (clock),
    .reset     (reset),
    .fill      (fill),
    .fill_tag  (pc_q[ADDR_W-1:3]),
    .fill_data (rdata_i),
    .inval     (inval),
    .look_tag  (pc_i[ADDR_W-1:3]),
    .hit       (hit),
    .line      (line)
  );
`else
  assign hit  = 1'b0;
  assign line = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IFU_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      fault_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      unique case (state)
        IFU_IDLE: begin
          pc_q   <= pc_i;
          kill_q <= 1'b0;
          if (misalign) begin
            inst_q  <= NOP;
            fault_q <= 1'b1;
            valid_q <= 1'b1;
            state   <= IFU_HOLD;
          end else if (hit) begin
            inst_q  <= pick_inst(line, pc_i[2]);
            fault_q <= 1'b0;
            valid_q <= 1'b1;
            state   <= IFU_HOLD;
          end else begin
            arvalid_q <= 1'b1;
            state     <= IFU_AR;
          end
        end
        IFU_AR: begin
          // arvalid is never withdrawn; remember a redirect seen meanwhile
          if (redirect_i)
            kill_q <= 1'b1;
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= (redirect_i || kill_q) ? IFU_DROP : IFU_R;
          end
        end
        IFU_R: begin
          if (rvalid_i) begin
            rready_q <= 1'b0;
            if (redirect_i) begin
              state <= IFU_IDLE;
            end else begin
              fault_q <= rresp_i != RESP_OKAY;
              inst_q  <= (rresp_i != RESP_OKAY) ? NOP
                       : pick_inst(rdata_i, pc_q[2]);
              valid_q <= 1'b1;
              state   <= IFU_HOLD;
            end
          end else if (redirect_i) begin
            state <= IFU_DROP;
          end
        end
        IFU_HOLD: begin
          if (redirect_i || if_ready_i) begin
            valid_q <= 1'b0;
            state   <= IFU_IDLE;
          end
        end
        IFU_DROP: begin
          if (rvalid_i) begin
            rready_q <= 1'b0;
            state    <= IFU_IDLE;
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

  assign pc_ready_o = valid_q && if_ready_i && !redirect_i;
  assign araddr_o   = {pc_q[ADDR_W-1:3], 3'b000};
  assign arvalid_o  = arvalid_q;
  assign rready_o   = rready_q;
  assign if_valid_o = valid_q;
  assign if_pc_o    = pc_q;
  assign if_inst_o  = inst_q;
  assign if_fault_o = fault_q;

endmodule
